// File: rtl/sisc_seq_ctrl_pkg.sv
// sisc_ctrl_pkg -- shared definitions for the SISC sequencing controller.
//   state_t        : controller state encoding
//   OP_*           : instruction opcode values
//   ALU_OP_*       : encodings driven on the alu_op control
package sisc_ctrl_pkg;

    typedef enum logic [2:0] {
        START0,
        START1,
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WRITEBACK,
        HALT
    } state_t;

    // Opcode values; callers cast to their own opcode width.
    localparam int OP_NOOP = 0;
    localparam int OP_LOD  = 1;
    localparam int OP_STR  = 2;
    localparam int OP_SWP  = 3;
    localparam int OP_BRA  = 4;
    localparam int OP_BRR  = 5;
    localparam int OP_BNE  = 6;
    localparam int OP_BNR  = 7;
    localparam int OP_ALU  = 8;
    localparam int OP_HLT  = 15;

    // alu_op encodings
    localparam logic [1:0] ALU_OP_RR = 2'b00;  // ALU instruction, register operand
    localparam logic [1:0] ALU_OP_RI = 2'b01;  // ALU instruction, immediate operand
    localparam logic [1:0] ALU_OP_AD = 2'b10;  // address/increment arithmetic
    localparam logic [1:0] ALU_OP_AI = 2'b11;  // address arithmetic with immediate

endpackage

// File: rtl/sisc_br_eval.sv
// sisc_br_eval -- branch-taken evaluation for the SISC controller.
//   opcode : IR opcode field
//   mm     : IR condition mask
//   stat   : status register
//   taken  : 1 when the branch opcode's condition holds (0 for non-branches)
//   br_sel : 1 for BRA/BNE, 0 for BRR/BNR and non-branches
module sisc_br_eval
    import sisc_ctrl_pkg::*;
#(
    parameter int OPC_W = 4,
    parameter int CC_W  = 4
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [CC_W-1:0]  mm,
    input  logic [CC_W-1:0]  stat,
    output logic             taken,
    output logic             br_sel
);

    logic hit;
    assign hit = |(stat & mm);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        taken  = 1'b0;
        br_sel = 1'b0;
        case (opcode)
            OPC_W'(OP_BRA): begin taken = hit;  br_sel = 1'b1; end
            OPC_W'(OP_BRR): begin taken = hit;                 end
            OPC_W'(OP_BNE): begin taken = !hit; br_sel = 1'b1; end
            OPC_W'(OP_BNR): begin taken = !hit;                end
            default: ;
        endcase
    end

endmodule

// File: rtl/sisc_seq_ctrl.sv
// sisc_seq_ctrl -- multi-cycle sequencing controller for the SISC datapath.
// Build option: define SISC_CTRL_MEMWAIT_EN to stretch MEM until mem_ack;
// otherwise MEM lasts one cycle and mem_ack is ignored.
// Ports:
//   clk, rst_f          : clock (rising edge), async active-low reset
//   opcode, mm, stat    : IR opcode, IR mode/condition mask, status register
//   mem_ack             : data memory completion
//   rf_we..dm_we,alu_op : datapath controls (combinational from state/IR/stat)
//   mem_req             : data memory request
//   halted              : HLT reached
//   retired             : retired-instruction count (wraps)
module sisc_seq_ctrl
    import sisc_ctrl_pkg::*;
#(
    parameter int OPC_W  = 4,
    parameter int CC_W   = 4,
    parameter int CNT_W  = 16,
    parameter int AM_IMM = 8
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic [OPC_W-1:0] opcode,
    input  logic [CC_W-1:0]  mm,
    input  logic [CC_W-1:0]  stat,
    input  logic             mem_ack,
    output logic             rf_we,
    output logic             wb_sel,
    output logic             rb_sel,
    output logic             pc_sel,
    output logic             pc_write,
    output logic             pc_rst,
    output logic             ir_load,
    output logic             br_sel,
    output logic             mux_16_sel,
    output logic             dm_we,
    output logic [1:0]       alu_op,
    output logic             mem_req,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t state_q, state_d;
    logic   br_taken, br_sel_w;
    logic   is_alu, is_imm, is_branch;

    sisc_br_eval #(.OPC_W(OPC_W), .CC_W(CC_W)) u_br_eval (
        .opcode (opcode),
        .mm     (mm),
        .stat   (stat),
        .taken  (br_taken),
        .br_sel (br_sel_w)
    );

    assign is_alu    = (opcode == OPC_W'(OP_ALU));
    assign is_imm    = (mm == CC_W'(AM_IMM));
    assign is_branch = (opcode >= OPC_W'(OP_BRA)) && (opcode <= OPC_W'(OP_BNR));

`ifndef SISC_CTRL_MEMWAIT_EN
    // Single-cycle MEM: the acknowledge has no effect on sequencing.
    logic mem_ack_unused;
    assign mem_ack_unused = mem_ack;
`endif

    // NOTE: state and counters use non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= START0;
            retired <= '0;
        end else begin
            state_q <= state_d;
            // An instruction retires leaving WRITEBACK, or leaving DECODE
            // straight back to FETCH (NOOP / branches). HLT never retires.
            if (state_q == WRITEBACK || (state_q == DECODE && state_d == FETCH))
                retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        rf_we      = 1'b0;
        wb_sel     = 1'b0;
        rb_sel     = 1'b0;
        pc_sel     = 1'b0;
        pc_write   = 1'b0;
        pc_rst     = 1'b0;
        ir_load    = 1'b0;
        br_sel     = 1'b0;
        mux_16_sel = 1'b0;
        dm_we      = 1'b0;
        alu_op     = 2'b00;
        mem_req    = 1'b0;
        halted     = 1'b0;

        case (state_q)
            START0: begin
                pc_rst  = 1'b1;
                alu_op  = ALU_OP_AD;
                state_d = START1;
            end
            START1: state_d = FETCH;
            FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                if (is_branch) begin
                    pc_sel   = 1'b1;
                    pc_write = br_taken;
                    br_sel   = br_sel_w;
                end
                if (opcode == OPC_W'(OP_HLT))
                    state_d = HALT;
                else if (opcode == OPC_W'(OP_NOOP) || is_branch)
                    state_d = FETCH;
                else
                    state_d = EXECUTE;
            end
            EXECUTE: begin
                if (is_alu) alu_op = is_imm ? ALU_OP_RI : ALU_OP_RR;
                else        alu_op = is_imm ? ALU_OP_AI : ALU_OP_AD;
                if (opcode == OPC_W'(OP_LOD) || opcode == OPC_W'(OP_STR))
                    state_d = MEM;
                else
                    state_d = WRITEBACK;
            end
            MEM: begin
                mem_req    = 1'b1;
                mux_16_sel = (mm == '0);
                dm_we      = (opcode == OPC_W'(OP_STR));
`ifdef SISC_CTRL_MEMWAIT_EN
                if (mem_ack) state_d = WRITEBACK;
`else
                state_d = WRITEBACK;
`endif
            end
            WRITEBACK: begin
                if (is_alu || opcode == OPC_W'(OP_SWP)) begin
                    rf_we = 1'b1;
                end else if (opcode == OPC_W'(OP_LOD)) begin
                    rf_we  = 1'b1;
                    wb_sel = 1'b1;
                end
                state_d = FETCH;
            end
            HALT: begin
                halted  = 1'b1;
                state_d = HALT;
            end
            default: state_d = START0;
        endcase
    end

endmodule

// File: doc/sisc_seq_ctrl.md
SISC_SEQ_CTRL -- requirements
Module: sisc_seq_ctrl

Interface
REQ-001 SHALL have parameters: OPC_W, default 4, opcode width; CC_W, default 4, condition-code/mode width; CNT_W, default 16, retired-instruction counter width; AM_IMM, default 8, immediate addressing-mode value.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst_f  in  1  asynchronous active-low reset.
- opcode  in  OPC_W  IR opcode field.
- mm  in  CC_W  IR mode/condition-mask field.
- stat  in  CC_W  status register.
- mem_ack  in  1  data memory completion.
- rf_we, wb_sel, rb_sel, pc_sel, pc_write, pc_rst, ir_load, br_sel, mux_16_sel, dm_we  out  1  datapath controls.
- alu_op  out  2  ALU function select.
- mem_req  out  1  data memory request.
- halted  out  1  HLT reached.
- retired  out  CNT_W  retired-instruction count.

Function
REQ-004 SHALL use states START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
REQ-005 Transitions SHALL be: START0->START1->FETCH->DECODE; DECODE->HALT on HLT (15); DECODE->FETCH on NOOP (0) or branch (4-7); DECODE->EXECUTE otherwise; EXECUTE->MEM on LOD (1)/STR (2), else ->WRITEBACK; MEM->WRITEBACK; WRITEBACK->FETCH; HALT->HALT.
REQ-006 Outputs SHALL be combinational from state, opcode, mm and stat; every output not named for a state SHALL be 0 in that state.
REQ-007 START0: pc_rst=1, alu_op=10. START1: all 0. FETCH: ir_load=1, pc_write=1.
REQ-008 DECODE, branches: pc_sel=1; taken condition is (stat&mm)!=0 for BRA(4)/BRR(5) and (stat&mm)==0 for BNE(6)/BNR(7); when taken, pc_write=1; br_sel=1 for BRA/BNE, 0 for BRR/BNR.
REQ-009 EXECUTE: alu_op = 01 if opcode==ALU_OP(8) and mm==AM_IMM; 00 if ALU_OP otherwise; 11 if non-ALU and mm==AM_IMM; 10 otherwise.
REQ-010 MEM: mem_req=1; mux_16_sel=1 when mm==0, else 0; dm_we=1 for STR for every MEM cycle.
REQ-011 WRITEBACK: rf_we=1, wb_sel=0 for ALU_OP and SWP(3); rf_we=1, wb_sel=1 for LOD; rf_we=0 otherwise.
REQ-012 HALT: halted=1, all others 0; exit only via reset.
REQ-013 Unlisted opcodes SHALL take the EXECUTE->WRITEBACK path with no register write.
REQ-014 retired SHALL increment by 1 on the clock edge leaving WRITEBACK, or leaving DECODE to FETCH; it wraps at 2^CNT_W-1 to 0; HLT is not counted.

Reset
REQ-015 rst_f low SHALL asynchronously force state START0 and retired=0; outputs take START0 values (pc_rst=1) while rst_f is low, including mid-instruction and in MEM with mem_req high.
REQ-016 After rst_f rises, the first FETCH SHALL occur on the third rising edge.

Configuration
REQ-017 With SISC_CTRL_MEMWAIT_EN defined, MEM SHALL hold until a cycle with mem_ack=1, then go to WRITEBACK; mem_ack=1 in the first MEM cycle gives one MEM cycle.
REQ-018 Without SISC_CTRL_MEMWAIT_EN, MEM SHALL last exactly one cycle and mem_ack SHALL be ignored.

Structure
REQ-019 Package sisc_ctrl_pkg SHALL hold the state encoding, opcode constants (NOOP..ALU_OP, HLT), and alu_op encodings.
REQ-020 Branch-taken evaluation SHALL be in sub-module sisc_br_eval (opcode, mm, stat -> taken, br_sel).

Verification
REQ-021 Reset release then ALU_OP with mm=0 -> START0, START1, FETCH, DECODE, EXECUTE (alu_op=00), WRITEBACK (rf_we=1), FETCH; retired=1.
REQ-022 BRA with stat=0100, mm=0100 -> DECODE pc_write=1, pc_sel=1, br_sel=1, then FETCH; with stat=0000 -> pc_write=0 in DECODE.
REQ-023 STR with mm=0 and MEMWAIT_EN, mem_ack low 3 cycles -> 4 MEM cycles with dm_we=1, mux_16_sel=1, mem_req=1.
REQ-024 LOD with mm=AM_IMM -> alu_op=11 in EXECUTE, mux_16_sel=0 in MEM, rf_we=1 and wb_sel=1 in WRITEBACK.
REQ-025 HLT -> halted=1 held for 10 cycles with retired unchanged; rst_f pulse low -> START0, retired=0.
REQ-026 retired at 2^CNT_W-1 (CNT_W=4) plus one NOOP -> retired=0.
